// File: rtl/disp_update_sched.sv
// rtl/disp_update_sched.sv - tear-free frame-synchronous commit of chicken/rabbit display values
// Optional DISP_FRAME_CNT_EN adds a 16-bit free-running frame_cnt_o.
module disp_update_sched #(
  parameter int unsigned HOLD_FRAMES = 1
) (
  input  logic        vga_clk_i,
  input  logic        rst_i,
  input  logic        chicken_valid_i,
  input  logic [31:0] chicken_data_i,
  output logic        chicken_ready_o,
  input  logic        rabbit_valid_i,
  input  logic [31:0] rabbit_data_i,
  output logic        rabbit_ready_o,
  input  logic        picture_over_i,
  input  logic        output_display_i,
  output logic [31:0] chicken_disp_o,
  output logic [31:0] rabbit_disp_o,
`ifdef DISP_FRAME_CNT_EN
  output logic [15:0] frame_cnt_o,
`endif
  output logic        disp_valid_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t      state;
  logic        chicken_pend;
  logic        rabbit_pend;
  logic [31:0] chicken_shadow;
  logic [31:0] rabbit_shadow;
  logic [7:0]  hold_cnt;
  logic        committed_once;

  logic chicken_acc;
  logic rabbit_acc;
  logic any_pend;

  assign chicken_ready_o = !chicken_pend && (state != COMMIT);
  assign rabbit_ready_o  = !rabbit_pend && (state != COMMIT);
  assign chicken_acc     = chicken_valid_i && chicken_ready_o;
  assign rabbit_acc      = rabbit_valid_i && rabbit_ready_o;
  assign any_pend        = chicken_pend || rabbit_pend;
  assign disp_valid_o    = output_display_i && committed_once;

  always_ff @(posedge vga_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      chicken_pend   <= 1'b0;
      rabbit_pend    <= 1'b0;
      chicken_shadow <= 32'd0;
      rabbit_shadow  <= 32'd0;
      chicken_disp_o <= 32'd0;
      rabbit_disp_o  <= 32'd0;
      hold_cnt       <= 8'd0;
      committed_once <= 1'b0;
    end else begin
      // ready is low during COMMIT, so acceptance never races with the pending clear
      if (chicken_acc) begin
        chicken_shadow <= chicken_data_i;
        chicken_pend   <= 1'b1;
      end
      if (rabbit_acc) begin
        rabbit_shadow <= rabbit_data_i;
        rabbit_pend   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (any_pend) state <= ARMED;
        end
        ARMED: begin
          if (picture_over_i) state <= COMMIT;
        end
        COMMIT: begin
          if (chicken_pend) begin
            chicken_disp_o <= chicken_shadow;
            chicken_pend   <= 1'b0;
          end
          if (rabbit_pend) begin
            rabbit_disp_o <= rabbit_shadow;
            rabbit_pend   <= 1'b0;
          end
          committed_once <= 1'b1;
          hold_cnt       <= 8'd0;
          // nothing can be pending once the commit clears the flags
          state          <= (HOLD_FRAMES > 1) ? HOLD : IDLE;
        end
        HOLD: begin
          if (picture_over_i) begin
            hold_cnt <= hold_cnt + 8'd1;
            if (hold_cnt + 8'd1 == HOLD_LAST) state <= any_pend ? ARMED : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISP_FRAME_CNT_EN
  always_ff @(posedge vga_clk_i or posedge rst_i) begin
    if (rst_i) frame_cnt_o <= 16'd0;
    else if (picture_over_i) frame_cnt_o <= frame_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_disp_update_sched.sv
// tb/tb_disp_update_sched.sv - vector table, corner sequences and random run vs reference model
module tb_disp_update_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cv = 1'b0, rv = 1'b0, po = 1'b0, od = 1'b0;
  logic [31:0] cd = '0, rd = '0;

  logic [1:0][31:0] cdisp, rdisp;
  logic [1:0]       cready, rready, dvalid;
`ifdef DISP_FRAME_CNT_EN
  logic [1:0][15:0] fcnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  disp_update_sched #(.HOLD_FRAMES(1)) dut1 (
    .vga_clk_i(clk), .rst_i(rst),
    .chicken_valid_i(cv), .chicken_data_i(cd), .chicken_ready_o(cready[0]),
    .rabbit_valid_i(rv), .rabbit_data_i(rd), .rabbit_ready_o(rready[0]),
    .picture_over_i(po), .output_display_i(od),
    .chicken_disp_o(cdisp[0]), .rabbit_disp_o(rdisp[0]),
`ifdef DISP_FRAME_CNT_EN
    .frame_cnt_o(fcnt[0]),
`endif
    .disp_valid_o(dvalid[0])
  );

  disp_update_sched #(.HOLD_FRAMES(3)) dut3 (
    .vga_clk_i(clk), .rst_i(rst),
    .chicken_valid_i(cv), .chicken_data_i(cd), .chicken_ready_o(cready[1]),
    .rabbit_valid_i(rv), .rabbit_data_i(rd), .rabbit_ready_o(rready[1]),
    .picture_over_i(po), .output_display_i(od),
    .chicken_disp_o(cdisp[1]), .rabbit_disp_o(rdisp[1]),
`ifdef DISP_FRAME_CNT_EN
    .frame_cnt_o(fcnt[1]),
`endif
    .disp_valid_o(dvalid[1])
  );

  // Reference model, index [dut][channel]; channel 0 = chicken, 1 = rabbit
  int          hf [2] = '{1, 3};
  logic [31:0] m_shadow [2][2];
  logic [31:0] m_disp [2][2];
  bit          m_pend [2][2];
  bit          m_once [2];
  bit          m_armed [2];
  bit          m_commit [2];
  int          m_gate [2];
  logic [15:0] m_fc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit acc [2];
    bit anyp;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int c = 0; c < 2; c++) begin
          m_shadow[d][c] = '0; m_disp[d][c] = '0; m_pend[d][c] = 0;
        end
        m_once[d] = 0; m_armed[d] = 0; m_commit[d] = 0; m_gate[d] = 0;
      end else begin
        acc[0] = cv && !m_pend[d][0] && !m_commit[d];
        acc[1] = rv && !m_pend[d][1] && !m_commit[d];
        anyp   = m_pend[d][0] || m_pend[d][1];
        if (m_commit[d]) begin
          for (int c = 0; c < 2; c++)
            if (m_pend[d][c]) begin
              m_disp[d][c] = m_shadow[d][c];
              m_pend[d][c] = 0;
            end
          m_once[d] = 1; m_commit[d] = 0; m_armed[d] = 0;
          m_gate[d] = hf[d] - 1;
        end else if (m_gate[d] > 0) begin
          if (po) begin
            m_gate[d]--;
            if (m_gate[d] == 0) m_armed[d] = anyp;
          end
        end else if (!m_armed[d]) begin
          m_armed[d] = anyp;
        end else if (po) begin
          m_commit[d] = 1; m_armed[d] = 0;
        end
        if (acc[0]) begin m_shadow[d][0] = cd; m_pend[d][0] = 1; end
        if (acc[1]) begin m_shadow[d][1] = rd; m_pend[d][1] = 1; end
      end
    end
    if (rst) m_fc = '0;
    else if (po) m_fc = m_fc + 16'd1;
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("model d%0d chicken_disp", d), cdisp[d], m_disp[d][0]);
      chk($sformatf("model d%0d rabbit_disp", d), rdisp[d], m_disp[d][1]);
      chk($sformatf("model d%0d chicken_ready", d), 32'(cready[d]), 32'(!m_pend[d][0] && !m_commit[d]));
      chk($sformatf("model d%0d rabbit_ready", d), 32'(rready[d]), 32'(!m_pend[d][1] && !m_commit[d]));
      chk($sformatf("model d%0d disp_valid", d), 32'(dvalid[d]), 32'(od && m_once[d]));
`ifdef DISP_FRAME_CNT_EN
      chk($sformatf("model d%0d frame_cnt", d), 32'(fcnt[d]), 32'(m_fc));
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_in(input bit rs, input bit cv_, input logic [31:0] cd_,
                        input bit rv_, input logic [31:0] rd_, input bit po_, input bit od_);
    rst = rs; cv = cv_; cd = cd_; rv = rv_; rd = rd_; po = po_; od = od_;
  endtask

  typedef struct {
    bit rs, cv, rv, po, od;
    logic [31:0] cd, rd;
    logic [31:0] ec, er;
    bit ecr, err, ev;
  } vec_t;

  function automatic vec_t mk(bit rs, bit cv_, logic [31:0] cd_, bit rv_, logic [31:0] rd_,
                              bit po_, bit od_, logic [31:0] ec, logic [31:0] er,
                              bit ecr, bit err, bit ev);
    vec_t v;
    v.rs = rs; v.cv = cv_; v.cd = cd_; v.rv = rv_; v.rd = rd_; v.po = po_; v.od = od_;
    v.ec = ec; v.er = er; v.ecr = ecr; v.err = err; v.ev = ev;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    localparam logic [31:0] R = 32'h1234_5678;
    tbl[0]  = mk(1, 0, 0,     0, 0, 0, 1, 0,     0, 1, 1, 0);
    tbl[1]  = mk(0, 1, 'hAA,  0, 0, 0, 1, 0,     0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 'hBB,  0, 0, 0, 1, 0,     0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0,     1, R, 1, 1, 0,     0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,     0, 0, 0, 1, 'hAA,  R, 1, 1, 1);
    tbl[5]  = mk(0, 0, 0,     0, 0, 0, 0, 'hAA,  R, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0,     0, 0, 0, 1, 'hAA,  R, 1, 1, 1);
    tbl[7]  = mk(0, 1, 'h11,  0, 0, 0, 0, 'hAA,  R, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0,     0, 0, 0, 0, 'hAA,  R, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0,     0, 0, 1, 0, 'hAA,  R, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,     0, 0, 0, 0, 'h11,  R, 1, 1, 0);
    tbl[11] = mk(0, 0, 0,     0, 0, 0, 1, 'h11,  R, 1, 1, 1);
    tbl[12] = mk(0, 0, 0,     0, 0, 1, 1, 'h11,  R, 1, 1, 1);
    tbl[13] = mk(0, 1, 'h22,  0, 0, 1, 1, 'h11,  R, 0, 1, 1);
    tbl[14] = mk(0, 0, 0,     0, 0, 1, 1, 'h11,  R, 0, 1, 1);
    tbl[15] = mk(0, 0, 0,     0, 0, 0, 1, 'h11,  R, 0, 1, 1);
    tbl[16] = mk(0, 0, 0,     0, 0, 1, 1, 'h11,  R, 0, 0, 1);
    tbl[17] = mk(0, 0, 0,     0, 0, 0, 1, 'h22,  R, 1, 1, 1);

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].rs, tbl[i].cv, tbl[i].cd, tbl[i].rv, tbl[i].rd, tbl[i].po, tbl[i].od);
      tick();
      chk($sformatf("vec%0d chicken_disp", i), cdisp[0], tbl[i].ec);
      chk($sformatf("vec%0d rabbit_disp", i), rdisp[0], tbl[i].er);
      chk($sformatf("vec%0d chicken_ready", i), 32'(cready[0]), 32'(tbl[i].ecr));
      chk($sformatf("vec%0d rabbit_ready", i), 32'(rready[0]), 32'(tbl[i].err));
      chk($sformatf("vec%0d disp_valid", i), 32'(dvalid[0]), 32'(tbl[i].ev));
    end

    // HOLD_FRAMES=3: next commit only on the third pulse after a commit
    set_in(1, 0, 0, 0, 0, 0, 1); tick();
    set_in(0, 1, 'h77, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick(); tick();
    set_in(0, 0, 0, 0, 0, 1, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick();
    chk("hold3 first commit", cdisp[1], 32'h77);
    set_in(0, 0, 0, 1, 'h55, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick();
    for (int p = 1; p <= 3; p++) begin
      set_in(0, 0, 0, 0, 0, 1, 1); tick();
      set_in(0, 0, 0, 0, 0, 0, 1); tick(); tick(); tick();
      chk($sformatf("hold3 after pulse %0d", p), rdisp[1], (p == 3) ? 32'h55 : 32'h0);
    end

    // Reset while ARMED with both channels pending
    set_in(1, 0, 0, 0, 0, 0, 1); tick();
    set_in(0, 1, 'hC1, 1, 'hC2, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick(); tick();
    set_in(1, 0, 0, 0, 0, 0, 1); tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("armed rst d%0d cdisp", d), cdisp[d], 32'h0);
      chk($sformatf("armed rst d%0d rdisp", d), rdisp[d], 32'h0);
      chk($sformatf("armed rst d%0d ready", d), 32'({cready[d], rready[d]}), 32'h3);
    end
    set_in(0, 0, 0, 0, 0, 1, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick(); tick();
    for (int d = 0; d < 2; d++)
      chk($sformatf("no commit after rst d%0d", d), cdisp[d] | rdisp[d], 32'h0);

    // Reset landing in the COMMIT cycle
    set_in(0, 1, 'hD1, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 1, 1); tick();
    set_in(1, 0, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); tick(); tick();
    for (int d = 0; d < 2; d++)
      chk($sformatf("commit rst d%0d cdisp", d), cdisp[d], 32'h0);

    for (int n = 0; n < 2000; n++) begin
      set_in($urandom_range(0, 199) == 0, 1'($urandom), $urandom,
             1'($urandom), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_update_sched.md
DISP_UPDATE_SCHED -- requirements
Module: disp_update_sched

Interface
REQ-001 Parameter HOLD_FRAMES, default 1, SHALL set the minimum number of frame-end pulses between two commits (legal range 1..255).
REQ-002 vga_clk_i  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 chicken_valid_i  input  1  SHALL indicate a valid write on chicken_data_i.
REQ-005 chicken_data_i  input  32  SHALL be the new chicken display value.
REQ-006 chicken_ready_o  output  1  SHALL indicate the chicken channel can accept a write this cycle.
REQ-007 rabbit_valid_i  input  1  SHALL indicate a valid write on rabbit_data_i.
REQ-008 rabbit_data_i  input  32  SHALL be the new rabbit display value.
REQ-009 rabbit_ready_o  output  1  SHALL indicate the rabbit channel can accept a write this cycle.
REQ-010 picture_over_i  input  1  SHALL be a one-cycle pulse marking the end of the active frame (start of vertical blanking).
REQ-011 output_display_i  input  1  SHALL be the display enable.
REQ-012 chicken_disp_o  output  32  SHALL be the committed chicken value driven to the colour stage.
REQ-013 rabbit_disp_o  output  32  SHALL be the committed rabbit value driven to the colour stage.
REQ-014 disp_valid_o  output  1  SHALL indicate the committed values are valid for display.

Function
REQ-015 Each channel SHALL have a 32-bit shadow register and a pending flag; a write is accepted when valid_i and ready_o are both high, loading the shadow and setting pending on the next edge.
REQ-016 A channel's ready_o SHALL equal (not pending) AND (state != COMMIT); it is combinational from registered state only.
REQ-017 The FSM SHALL have states IDLE, ARMED, COMMIT and HOLD.
REQ-018 IDLE -> ARMED when any pending flag is set; ARMED -> COMMIT on the cycle picture_over_i is high.
REQ-019 COMMIT SHALL last exactly one cycle: copy every pending shadow to its disp output, clear those pending flags, and leave non-pending disp outputs unchanged.
REQ-020 COMMIT -> HOLD if HOLD_FRAMES > 1; otherwise COMMIT -> ARMED if a write was accepted during COMMIT-adjacent cycles and pending is set, else IDLE.
REQ-021 HOLD SHALL count picture_over_i pulses with an 8-bit counter cleared on entry, and exit to ARMED (any pending) or IDLE (none) on the cycle the count reaches HOLD_FRAMES-1.
REQ-022 Writes SHALL be accepted in IDLE, ARMED and HOLD; a write accepted in the same cycle picture_over_i arrives in ARMED SHALL be included in the following COMMIT.
REQ-023 A picture_over_i pulse in IDLE or COMMIT SHALL be ignored.
REQ-024 Disp outputs SHALL change only on the COMMIT edge (tear-free); latency from picture_over_i in ARMED to updated disp outputs is 2 edges.
REQ-025 disp_valid_o SHALL equal output_display_i AND a sticky committed_once flag set by the first COMMIT; commits proceed regardless of output_display_i.

Reset
REQ-026 While rst_i is high: state IDLE, pending flags 0, shadows 0, chicken_disp_o = rabbit_disp_o = 0, committed_once 0, hold counter 0; hence disp_valid_o = 0 and both ready_o = 1.
REQ-027 Reset asserted mid-COMMIT or mid-HOLD SHALL discard all pending data with no partial update of disp outputs after release.

Configuration
REQ-028 With DISP_FRAME_CNT_EN defined, a 16-bit output frame_cnt_o SHALL increment on every picture_over_i pulse in any state, wrapping 0xFFFF -> 0x0000, reset to 0.
REQ-029 Without DISP_FRAME_CNT_EN, frame_cnt_o and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset release, chicken write 0x0000_00AA, pulse picture_over_i -> chicken_disp_o = 0xAA 2 edges later, rabbit_disp_o stays 0, disp_valid_o = 1 with output_display_i = 1.
REQ-031 Second chicken write while pending -> chicken_ready_o = 0, value not accepted, first value committed.
REQ-032 Rabbit write 0x1234_5678 in the same cycle as picture_over_i in ARMED -> included in that commit.
REQ-033 HOLD_FRAMES = 3, writes after a commit -> next commit only on the third subsequent picture_over_i pulse.
REQ-034 output_display_i = 0 during a commit -> disp outputs update, disp_valid_o = 0; raising output_display_i gives disp_valid_o = 1 in the same cycle.
REQ-035 rst_i pulse while ARMED with both channels pending -> both disp outputs 0, both ready_o = 1, no commit on the next picture_over_i.
